spi_rx_deserializer: RTL



---
 rtl/spi_rx_deserializer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/spi_rx_deserializer.sv
// spi_rx_deserializer
//   Samples miso on each rising edge of the serializer's spi_clk during the
//   data phase of a flash read, assembles DATAW-bit words MSB-first and
//   presents them on a valid/ready interface. A word that completes while the
//   output is stalled and cannot be held is dropped and flags a sticky err.
//   spi_clk is a registered signal in the clk domain, so its rising edge is
//   detected rather than used as a clock.
//
// Optional build macro:
//   DESER_SKID_EN - adds a one-word skid register behind data_out; err is then
//                   raised only when both data_out and the skid are occupied.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   n_cs       in   chip select from serializer, active low
//   spi_clk    in   SPI clock from serializer, synchronous to clk
//   data_phase in   high while serializer is past command/address phase
//   miso       in   serial data from flash
//   data_out   out  assembled word, MSB = first bit received
//   valid_out  out  data_out holds an unconsumed word
//   ready_in   in   consumer accepts when valid_out && ready_in
//   err        out  sticky overflow flag
//   err_clr    in   synchronous clear of err
module spi_rx_deserializer #(
  parameter int DATAW = 8,
  parameter int CNTW  = $clog2(DATAW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             n_cs,
  input  logic             spi_clk,
  input  logic             data_phase,
  input  logic             miso,
  output logic [DATAW-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             err,
  input  logic             err_clr
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [CNTW-1:0]  cnt, cnt_nx;
  logic [DATAW-1:0] shift, shift_nx;
  logic [DATAW-1:0] word;
  logic             spi_clk_q;
  logic             sample;
  logic             complete;
  logic             transfer;
  logic             stall;
  logic             overflow;

  // Rising edge of spi_clk, qualified so edges outside an active data phase
  // have no effect at all.
  assign sample   = spi_clk && !spi_clk_q && !n_cs && data_phase;
  assign word     = {shift[DATAW-2:0], miso};
  assign transfer = valid_out && ready_in;
  assign stall    = valid_out && !ready_in;

  // Edge-detect and FSM state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_clk_q <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      shift     <= '0;
    end else begin
      spi_clk_q <= spi_clk;
      state     <= state_nx;
      cnt       <= cnt_nx;
      shift     <= shift_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shift_nx = shift;
    complete = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (sample) begin
          shift_nx = word;
          cnt_nx   = CNTW'(1);
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (n_cs || !data_phase) begin
          // Transaction ended mid-word: the partial word is silently dropped.
          cnt_nx   = '0;
          state_nx = IDLE;
        end else if (sample) begin
          shift_nx = word;
          if (cnt == CNTW'(DATAW - 1)) begin
            complete = 1'b1;
            cnt_nx   = '0;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + CNTW'(1);
          end
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // Output register stage
`ifdef DESER_SKID_EN
  logic [DATAW-1:0] skid_data;
  logic             skid_vld;

  assign overflow = complete && stall && skid_vld;

  // The skid is only ever occupied while data_out is, so word order is kept by
  // always refilling data_out from the skid before taking a new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      skid_data <= '0;
      skid_vld  <= 1'b0;
    end else if (transfer) begin
      if (skid_vld) begin
        data_out <= skid_data;
        if (complete) begin
          skid_data <= word;
        end else begin
          skid_vld <= 1'b0;
        end
      end else if (complete) begin
        data_out <= word;
      end else begin
        valid_out <= 1'b0;
      end
    end else if (stall) begin
      if (complete && !skid_vld) begin
        skid_data <= word;
        skid_vld  <= 1'b1;
      end
    end else if (complete) begin
      data_out  <= word;
      valid_out <= 1'b1;
    end
  end
`else
  assign overflow = complete && stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (complete && !stall) begin
      // Covers both an empty register and a same-cycle transfer.
      data_out  <= word;
      valid_out <= 1'b1;
    end else if (transfer) begin
      valid_out <= 1'b0;
    end
  end
`endif

  // Sticky error; a new overflow takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (overflow) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule
